// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock divider / clock-enable generator.
// Ports:
//   clk, rst_n              board clock and asynchronous active-low reset
//   cfg_we, cfg_ch          one-cycle configuration write strobe and target channel
//   cfg_div/high/phase      period, high time and counter start value for the write
//   en, sync_start          per-channel enable, realign all counters to their phase
//   locked                  warmup complete
//   clk_out, tick           registered divided outputs and end-of-period pulses
//   cfg_err                 one-cycle pulse when a write is rejected
module clk_div_gen #(
    parameter int CH       = 3,
    parameter int CNT_W    = 16,
    parameter int LOCK_CYC = 64,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic [CH-1:0]    en,
    input  logic             sync_start,
    output logic             locked,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick,
    output logic             cfg_err
);
    localparam int LW = $clog2(LOCK_CYC);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] div_q [CH], div_d [CH];
    logic [CNT_W-1:0] high_q [CH], high_d [CH];
    logic [CNT_W-1:0] phase_q [CH], phase_d [CH];
    logic [CNT_W-1:0] sdiv_q [CH], sdiv_d [CH];
    logic [CNT_W-1:0] shigh_q [CH], shigh_d [CH];
    logic [CNT_W-1:0] sphase_q [CH], sphase_d [CH];
    logic [CNT_W-1:0] cnt_q [CH], cnt_d [CH];
    logic [CH-1:0]    pend_q, pend_d, out_q, out_d, tick_q, tick_d;
    logic             cfg_ok, sync;
    logic [CH-1:0]    wr, pend, wrap, hold, apply;

    always_comb begin
        cfg_ok = cfg_we && ({1'b0, cfg_ch} < 5'(CH)) && (cfg_div > ONE) && (cfg_high != '0)
                 && (cfg_high < cfg_div) && (cfg_phase < cfg_div);
        err_d = cfg_we && !cfg_ok;
        sync = sync_start && locked_q;
        locked_d = locked_q || (lock_cnt_q == LW'(LOCK_CYC - 1));
        lock_cnt_d = locked_q ? lock_cnt_q : lock_cnt_q + LW'(1);
        wr = '0;
        pend = '0;
        wrap = '0;
        hold = '0;
        apply = '0;
        pend_d = '0;
        out_d = '0;
        tick_d = '0;
        for (int k = 0; k < CH; k++) begin
            // An accepted write is forwarded so a same-cycle load (sync, wrap,
            // parked channel) already uses the new triple.
            wr[k] = cfg_ok && (cfg_ch == 4'(k));
            sdiv_d[k] = wr[k] ? cfg_div : sdiv_q[k];
            shigh_d[k] = wr[k] ? cfg_high : shigh_q[k];
            sphase_d[k] = wr[k] ? cfg_phase : sphase_q[k];
            pend[k] = wr[k] || pend_q[k];
            wrap[k] = cnt_q[k] == div_q[k] - ONE;
            // Parked at phase while unlocked/disabled, or realigned by sync.
            hold[k] = !locked_q || !en[k] || sync;
            apply[k] = pend[k] && (hold[k] || wrap[k]);
            div_d[k] = apply[k] ? sdiv_d[k] : div_q[k];
            high_d[k] = apply[k] ? shigh_d[k] : high_q[k];
            phase_d[k] = apply[k] ? sphase_d[k] : phase_q[k];
            pend_d[k] = pend[k] && !apply[k];
            cnt_d[k] = (hold[k] || apply[k]) ? phase_d[k] : wrap[k] ? '0 : cnt_q[k] + ONE;
            out_d[k] = locked_q && en[k] && (cnt_q[k] < high_q[k]);
            // A sync truncates the period, so its end is not reported.
            tick_d[k] = locked_q && en[k] && wrap[k] && !sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            locked_q <= 1'b0;
            err_q <= 1'b0;
            pend_q <= '0;
            out_q <= '0;
            tick_q <= '0;
            for (int k = 0; k < CH; k++) begin
                div_q[k] <= CNT_W'(DEF_DIV);
                high_q[k] <= CNT_W'(DEF_HIGH);
                phase_q[k] <= '0;
                sdiv_q[k] <= CNT_W'(DEF_DIV);
                shigh_q[k] <= CNT_W'(DEF_HIGH);
                sphase_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q <= locked_d;
            err_q <= err_d;
            pend_q <= pend_d;
            out_q <= out_d;
            tick_q <= tick_d;
            div_q <= div_d;
            high_q <= high_d;
            phase_q <= phase_d;
            sdiv_q <= sdiv_d;
            shigh_q <= shigh_d;
            sphase_q <= sphase_d;
            cnt_q <= cnt_d;
        end
    end

    assign locked = locked_q;
    assign clk_out = out_q;
    assign tick = tick_q;
    assign cfg_err = err_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed, table-driven and random checks of clk_div_gen against a cycle model.
module tb_clk_div_gen;
    localparam int CH = 3, CNT_W = 16, LOCK_CYC = 64, DEF_DIV = 2, DEF_HIGH = 1;

    logic clk = 1'b1, rst_n = 1'b0, cfg_we = 1'b0, sync_start = 1'b0;
    logic [3:0] cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
    logic [CH-1:0] en = '1;
    logic locked, cfg_err;
    logic [CH-1:0] clk_out, tick;

    always #20 clk = ~clk;

    clk_div_gen #(.CH(CH), .CNT_W(CNT_W), .LOCK_CYC(LOCK_CYC), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_high(cfg_high), .cfg_phase(cfg_phase), .en(en), .sync_start(sync_start),
        .locked(locked), .clk_out(clk_out), .tick(tick), .cfg_err(cfg_err)
    );

    int total = 0, bad = 0;

    // Reference: each channel is a position within its period plus active/shadow settings.
    int md[CH], mh[CH], mp[CH], sd[CH], sh[CH], sp[CH], mc[CH];
    bit mpend[CH];
    int mlock;
    bit mlocked, merr;
    bit [CH-1:0] mout, mtick;

    typedef struct { int ch; int dv; int hi; int ph; bit err; } vec_t;
    vec_t vecs[8];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void mreset();
        mlock = 0; mlocked = 0; merr = 0; mout = '0; mtick = '0;
        for (int i = 0; i < CH; i++) begin
            md[i] = DEF_DIV; mh[i] = DEF_HIGH; mp[i] = 0;
            sd[i] = DEF_DIV; sh[i] = DEF_HIGH; sp[i] = 0;
            mc[i] = 0; mpend[i] = 0;
        end
    endfunction

    function automatic void mstep();
        bit ok, sy, run, eop;
        ok = cfg_we && cfg_ch < CH && cfg_div >= 2 && cfg_high >= 1 && cfg_high < cfg_div && cfg_phase < cfg_div;
        sy = sync_start && mlocked;
        merr = cfg_we && !ok;
        for (int i = 0; i < CH; i++) begin
            run = mlocked && en[i];
            eop = (mc[i] == md[i] - 1);
            mout[i] = run && (mc[i] < mh[i]);
            mtick[i] = run && eop && !sy;
            if (ok && cfg_ch == i) begin
                sd[i] = cfg_div; sh[i] = cfg_high; sp[i] = cfg_phase; mpend[i] = 1;
            end
            if (mpend[i] && (!run || sy || eop)) begin
                md[i] = sd[i]; mh[i] = sh[i]; mp[i] = sp[i]; mpend[i] = 0; mc[i] = mp[i];
            end else if (!run || sy) mc[i] = mp[i];
            else mc[i] = eop ? 0 : mc[i] + 1;
        end
        if (!mlocked) begin
            if (mlock == LOCK_CYC - 1) mlocked = 1;
            else mlock++;
        end
    endfunction

    task automatic cycle();
        mstep();
        @(posedge clk);
        #1;
        chk("cycle", {locked, clk_out, tick, cfg_err}, {mlocked, mout, mtick, merr});
        cfg_we = 1'b0;
        sync_start = 1'b0;
    endtask

    task automatic wr(input int c, input int d, input int h, input int p);
        cfg_we = 1'b1; cfg_ch = 4'(c); cfg_div = CNT_W'(d); cfg_high = CNT_W'(h); cfg_phase = CNT_W'(p);
        cycle();
    endtask

    task automatic warmup(input string nm);
        int lock_at = 0;
        for (int n = 1; n <= LOCK_CYC + 2; n++) begin
            cycle();
            if (n <= LOCK_CYC) chk({nm, "_quiet"}, {clk_out, tick}, 0);
            if (locked === 1'b1 && lock_at == 0) lock_at = n;
            if (n == LOCK_CYC + 1) chk({nm, "_first"}, clk_out, 3'b111);
            if (n == LOCK_CYC + 2) chk({nm, "_tick"}, {clk_out, tick}, 6'b000111);
        end
        chk({nm, "_lock_cycle"}, lock_at, LOCK_CYC);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 4, 2, 0, 1};
        vecs[1] = '{0, 1, 1, 0, 1};
        vecs[2] = '{0, 4, 4, 0, 1};
        vecs[3] = '{0, 6, 2, 6, 1};
        vecs[4] = '{0, 4, 0, 0, 1};
        vecs[5] = '{15, 5, 2, 0, 1};
        vecs[6] = '{1, 5, 2, 0, 0};
        vecs[7] = '{2, 2, 1, 1, 0};
        mreset();
        #1;
        chk("reset", {locked, clk_out, tick, cfg_err}, 0);
        #99;
        rst_n = 1'b1;
        warmup("lock");
        for (int j = 0; j < 6; j++) begin
            cycle();
            chk("def_tick", tick, (j % 2 == 1) ? 3'b111 : 3'b000);
        end
        // new ch1 setting waits for the current period to end
        wr(1, 5, 2, 0);
        for (int k = 0; k < 4 && tick[1] !== 1'b1; k++) cycle();
        chk("shadow_wrap", tick[1], 1);
        for (int j = 0; j < 10; j++) begin
            cycle();
            chk("shadow_out", clk_out[1], (j % 5) < 2);
            chk("shadow_tick", tick[1], (j % 5) == 4);
        end
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].ch, vecs[i].dv, vecs[i].hi, vecs[i].ph);
            chk("err_vec", cfg_err, vecs[i].err);
            cycle();
            chk("err_clear", cfg_err, 0);
        end
        // ch2 write lands in the same cycle as the sync pulse
        wr(0, 4, 2, 0);
        sync_start = 1'b1;
        wr(2, 4, 2, 2);
        chk("sync_no_tick", tick, 0);
        for (int j = 0; j < 8; j++) begin
            cycle();
            chk("sync_c0", clk_out[0], (j % 4) < 2);
            chk("sync_c2", clk_out[2], (j % 4) >= 2);
        end
        en[1] = 1'b0;
        for (int j = 0; j < 7; j++) begin
            cycle();
            chk("dis_out", {clk_out[1], tick[1]}, 0);
        end
        en[1] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cycle();
            chk("reen_out", clk_out[1], (j % 5) < 2);
            chk("reen_tick", tick[1], (j % 5) == 4);
        end
        #10;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {locked, clk_out, tick, cfg_err}, 0);
        mreset();
        @(posedge clk);
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        warmup("relock");
        for (int j = 0; j < 400; j++) begin
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_ch = 4'($urandom_range(0, 3));
            cfg_div = CNT_W'($urandom_range(0, 7));
            cfg_high = CNT_W'($urandom_range(0, 7));
            cfg_phase = CNT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) begin
                int b = $urandom_range(0, CH - 1);
                en[b] = ~en[b];
            end
            sync_start = ($urandom_range(0, 19) == 0);
            cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Multi-channel programmable clock-enable/divider generator that drives LED and low-rate logic from the single 25 MHz board clock.
- Successor to the fixed three-output PLL LED top: channel count, counter width, per-channel divide, duty and phase are all run-time configurable.
- Adds a lock-warmup indicator, synchronous phase realignment and configuration error reporting.
- Sits between the board clock input and the LED/peripheral drivers.

Parameters:
- CH, 3, number of output channels (1..16)
- CNT_W, 16, width of divide/high/phase fields and channel counters
- LOCK_CYC, 64, clk cycles after reset release before locked asserts (>=2)
- DEF_DIV, 2, reset divide ratio of every channel (>=2)
- DEF_HIGH, 1, reset high-time of every channel (1..DEF_DIV-1)

Ports:
- clk  in  1  system clock, 25 MHz
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  4  target channel index
- cfg_div  in  CNT_W  period in clk cycles
- cfg_high  in  CNT_W  cycles output is high per period
- cfg_phase  in  CNT_W  counter start value
- en  in  CH  per-channel enable
- sync_start  in  1  reload all channel counters with their phase
- locked  out  1  warmup complete
- clk_out  out  CH  divided square outputs (registered)
- tick  out  CH  one-cycle pulse at end of each period (registered)
- cfg_err  out  1  one-cycle pulse: last write rejected

Behaviour:
- Reset (rst_n=0, async): locked=0, clk_out=0, tick=0, cfg_err=0, lock counter=0. Every channel: active div=DEF_DIV, high=DEF_HIGH, phase=0, counter=0, pending flag clear.
- Lock:
  - Lock counter increments each cycle after reset release.
  - When it equals LOCK_CYC-1, locked goes 1 at the next edge and stays 1 until reset.
  - While locked=0, all channel counters are held at their phase and clk_out/tick are forced 0.
- Channel counter (locked=1, en[i]=1): cnt advances 0..div-1 then wraps to 0.
- Channel counter (en[i]=0): cnt is held at phase, clk_out[i]=0, tick[i]=0. On re-enable, counting restarts from phase.
- Output decode, one-cycle latency:
  - clk_out[i](t+1) = locked & en[i] & (cnt(t) < high).
  - tick[i](t+1) = locked & en[i] & (cnt(t) == div-1).
- Config validation on cfg_we; the write is rejected if any of the following holds:
  - cfg_ch >= CH
  - cfg_div < 2
  - cfg_high == 0 or cfg_high >= cfg_div
  - cfg_phase >= cfg_div
- Rejected write: cfg_err=1 on the next cycle; no state changes.
- Accepted write:
  - The triple is latched into the channel's shadow and the pending flag is set.
  - Enabled channel: shadow is copied to active at the wrap cycle (cnt==div-1), and the counter then loads the new phase instead of 0.
  - Disabled channel, or locked=0: shadow is applied on the next edge.
  - A second write before wrap overwrites the shadow; last write wins.
- sync_start (locked=1): on the next edge every channel loads phase, applying any pending shadow first. No tick is generated for the truncated period. sync_start takes priority over a same-cycle wrap.
- sync_start while locked=0: ignored.
- cfg_we in the same cycle as sync_start: the write is validated normally. If accepted, the new value takes effect at that sync load.
- Arithmetic: counters are unsigned CNT_W; there is no overflow because div <= 2^CNT_W-1.
- Reset mid-operation: all state returns to reset values immediately (async), and lock warmup restarts.

Test Plan:
- Lock warmup: release rst_n at t=100 ns with en=3'b111 -> locked rises exactly LOCK_CYC=64 clk cycles later; clk_out/tick are 0 throughout, and the first clk_out[0] edge appears the cycle after locked.
- Defaults: after lock, all channels toggle at div=2 (12.5 MHz, 50% duty) and tick every 2 cycles.
- Config plus shadow: write ch1 div=5, high=2, phase=0 mid-period -> the old period completes, then clk_out[1] runs high 2 / low 3 and tick[1] fires every 5 cycles.
- Error paths: writes with cfg_ch=3; div=1; high=4 with div=4; phase=6 with div=6 -> cfg_err pulses once per write and all channel outputs are unchanged.
- Phase/sync: ch0 div=4 high=2 phase=0, ch2 div=4 high=2 phase=2, then pulse sync_start -> clk_out[2] is exactly 2 cycles offset from clk_out[0] (inverted), and no tick appears on the sync cycle.
- Enable/reset: drop en[1] for 7 cycles -> clk_out[1]=0, then restart from phase. Assert rst_n=0 mid-period -> outputs 0 immediately, defaults restored, and locked re-asserts 64 cycles after release.
